reset_seq: RTL and testbench

RESET_SEQ -- requirements
Module: reset_seq

---
 rtl/reset_seq.sv | 187 ++++++++++++++++++
 tb/tb_reset_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_seq.sv
// Power-on reset sequencer: pulses the PLL reset, qualifies a stable lock, then
// releases N_RST downstream reset domains one after another and supervises lock.
module reset_seq #(
    parameter int unsigned PLL_RST_LEN  = 16,
    parameter int unsigned LOCK_STABLE  = 64,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned STAGGER      = 8,
    parameter int unsigned N_RST        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             req_restart,
    output logic             pll_reset_n,
    output logic [N_RST-1:0] rst_out,
    output logic             ready,
    output logic [3:0]       fault_cnt
);

    typedef enum logic [1:0] {
        PLLRST    = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [15:0] RST_LAST    = 16'(PLL_RST_LEN - 32'd1);
    localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE - 32'd1);
    localparam logic [15:0] TMO_LAST    = 16'(LOCK_TIMEOUT - 32'd1);

    // Counter value seen on the edge that releases domain k.
    function automatic logic [15:0] rel_point(input int unsigned k);
        return 16'((k + 32'd1) * STAGGER - 32'd1);
    endfunction

    localparam logic [15:0] REL_LAST = rel_point(N_RST - 32'd1);

    state_t           state_r, state_s;
    logic [15:0]      cnt_r, cnt_s;
    logic [15:0]      tmo_r, tmo_s;
    logic             lock_meta_r, lock_r;
    logic             pll_reset_n_r, pll_s;
    logic [N_RST-1:0] rst_out_r, rst_s, rel_mask_s;
    logic             ready_r, ready_s;
    logic [3:0]       fault_cnt_r, fault_s;
    logic             go_rst_s, fault_inc_s;

    // Lock synchronizer; held clear while the PLL itself is in reset so a
    // stale lock from before the pulse is never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_r <= 1'b0;
            lock_r      <= 1'b0;
        end else if (state_r == PLLRST) begin
            lock_meta_r <= 1'b0;
            lock_r      <= 1'b0;
        end else begin
            lock_meta_r <= pll_lock;
            lock_r      <= lock_meta_r;
        end
    end

    // Which domains are due for release on this edge.
    always_comb begin
        rel_mask_s = '0;
        for (int k = 0; k < N_RST; k++) begin
            rel_mask_s[k] = (cnt_r == rel_point(k));
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r + 16'd1;
        tmo_s       = 16'd0;
        pll_s       = pll_reset_n_r;
        rst_s       = rst_out_r;
        ready_s     = ready_r;
        go_rst_s    = 1'b0;
        fault_inc_s = 1'b0;
        case (state_r)
            PLLRST: begin
                if (cnt_r == RST_LAST) begin
                    state_s = WAIT_LOCK;
                    cnt_s   = 16'd0;
                    pll_s   = 1'b1;
                end else begin
                    pll_s = 1'b0;
                end
            end
            WAIT_LOCK: begin
                tmo_s = tmo_r + 16'd1;
                if (!lock_r) begin
                    cnt_s = 16'd0;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
                if (req_restart) begin
                    go_rst_s    = 1'b1;
                    fault_inc_s = (tmo_r == TMO_LAST) && !(lock_r && cnt_r == STABLE_LAST);
                end else if (lock_r && cnt_r == STABLE_LAST) begin
                    state_s = RELEASE;
                    cnt_s   = 16'd0;
                    tmo_s   = 16'd0;
                end else if (tmo_r == TMO_LAST) begin
                    go_rst_s    = 1'b1;
                    fault_inc_s = 1'b1;
                end else begin
                    state_s = WAIT_LOCK;
                end
            end
            RELEASE: begin
                if (!lock_r) begin
                    go_rst_s    = 1'b1;
                    fault_inc_s = 1'b1;
                end else if (req_restart) begin
                    go_rst_s = 1'b1;
                end else begin
                    rst_s = rst_out_r & ~rel_mask_s;
                    if (cnt_r == REL_LAST) begin
                        state_s = RUN;
                        ready_s = 1'b1;
                        cnt_s   = 16'd0;
                    end else begin
                        state_s = RELEASE;
                    end
                end
            end
            RUN: begin
                cnt_s = cnt_r;
                if (!lock_r) begin
                    go_rst_s    = 1'b1;
                    fault_inc_s = 1'b1;
                end else if (req_restart) begin
                    go_rst_s = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                go_rst_s = 1'b1;
            end
        endcase
        if (go_rst_s) begin
            state_s = PLLRST;
            cnt_s   = 16'd0;
            tmo_s   = 16'd0;
            pll_s   = 1'b0;
            rst_s   = '1;
            ready_s = 1'b0;
        end else begin
            state_s = state_s;
        end
        if (fault_inc_s && fault_cnt_r != 4'd15) begin
            fault_s = fault_cnt_r + 4'd1;
        end else begin
            fault_s = fault_cnt_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= PLLRST;
            cnt_r         <= 16'd0;
            tmo_r         <= 16'd0;
            pll_reset_n_r <= 1'b0;
            rst_out_r     <= '1;
            ready_r       <= 1'b0;
            fault_cnt_r   <= 4'd0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            tmo_r         <= tmo_s;
            pll_reset_n_r <= pll_s;
            rst_out_r     <= rst_s;
            ready_r       <= ready_s;
            fault_cnt_r   <= fault_s;
        end
    end

    assign pll_reset_n = pll_reset_n_r;
    assign rst_out     = rst_out_r;
    assign ready       = ready_r;
    assign fault_cnt   = fault_cnt_r;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: default-parameter instance for sequencing and
// supervision, small-parameter instance for fault counter saturation.
module tb_reset_seq;

    logic       clk = 1'b0;
    logic       rst_n, pll_lock, req_restart;
    logic       pll_reset_n, ready;
    logic [2:0] rst_out;
    logic [3:0] fault_cnt;

    logic       rst2_n, pll_lock2, req2;
    logic       pll_reset_n2, ready2;
    logic [1:0] rst_out2;
    logic [3:0] fault_cnt2;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reset_seq dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .req_restart(req_restart),
        .pll_reset_n(pll_reset_n), .rst_out(rst_out), .ready(ready), .fault_cnt(fault_cnt)
    );

    reset_seq #(.PLL_RST_LEN(4), .LOCK_STABLE(4), .LOCK_TIMEOUT(32), .STAGGER(2), .N_RST(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .pll_lock(pll_lock2), .req_restart(req2),
        .pll_reset_n(pll_reset_n2), .rst_out(rst_out2), .ready(ready2), .fault_cnt(fault_cnt2)
    );

    // Polls at negedges until the selected output of dut equals val; at = -1 on timeout.
    // which: 0 pll_reset_n, 1..3 rst_out[0..2], 4 ready.
    task automatic wait_until(input int which, input logic val, input int bound, output int at);
        logic s;
        at = -1;
        for (int i = 0; i < bound; i++) begin
            case (which)
                0: s = pll_reset_n;
                1: s = rst_out[0];
                2: s = rst_out[1];
                3: s = rst_out[2];
                default: s = ready;
            endcase
            if (s === val) begin
                at = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rst2_n = 1'b0;
        pll_lock = 1'b1; req_restart = 1'b0;
        pll_lock2 = 1'b0; req2 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (pll_reset_n !== 1'b0 || rst_out !== 3'b111 || ready !== 1'b0 || fault_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_values: got pll=%b rst=%b rdy=%b flt=%0d want 0 111 0 0",
                     pll_reset_n, rst_out, ready, fault_cnt);
        end
    endtask

    task automatic test_bringup;
        int b, at;
        rst_n = 1'b1;
        b = cyc;
        @(negedge clk);
        n_checks++;
        if (pll_reset_n !== 1'b0) begin
            n_fail++; $display("FAIL pll_pulse_start: got %b want 0", pll_reset_n);
        end
        wait_until(0, 1'b1, 40, at);
        n_checks++;
        if (at !== b + 16) begin n_fail++; $display("FAIL pll_pulse_len: got %0d want %0d", at - b, 16); end
        wait_until(1, 1'b0, 200, at);
        n_checks++;
        if (at !== b + 90) begin n_fail++; $display("FAIL rel0_time: got %0d want %0d", at - b, 90); end
        wait_until(2, 1'b0, 40, at);
        n_checks++;
        if (at !== b + 98) begin n_fail++; $display("FAIL rel1_time: got %0d want %0d", at - b, 98); end
        n_checks++;
        if (rst_out[0] !== 1'b0) begin n_fail++; $display("FAIL rel0_stays: got %b want 0", rst_out[0]); end
        wait_until(3, 1'b0, 40, at);
        n_checks++;
        if (at !== b + 106) begin n_fail++; $display("FAIL rel2_time: got %0d want %0d", at - b, 106); end
        n_checks++;
        if (ready !== 1'b1 || fault_cnt !== 4'd0) begin
            n_fail++; $display("FAIL ready_with_rel2: got rdy=%b flt=%0d want 1 0", ready, fault_cnt);
        end
    endtask

    task automatic test_lock_loss;
        int b, at;
        pll_lock = 1'b0;
        b = cyc;
        repeat (2) @(negedge clk);
        n_checks++;
        if (rst_out !== 3'b000 || ready !== 1'b1) begin
            n_fail++; $display("FAIL loss_sync_delay: got rst=%b rdy=%b want 000 1", rst_out, ready);
        end
        @(negedge clk);
        n_checks++;
        if (rst_out !== 3'b111 || ready !== 1'b0 || pll_reset_n !== 1'b0 || fault_cnt !== 4'd1) begin
            n_fail++; $display("FAIL loss_outputs: got rst=%b rdy=%b pll=%b flt=%0d want 111 0 0 1",
                               rst_out, ready, pll_reset_n, fault_cnt);
        end
        pll_lock = 1'b1;
        wait_until(4, 1'b1, 300, at);
        n_checks++;
        if (at !== b + 109 || fault_cnt !== 4'd1) begin
            n_fail++; $display("FAIL loss_rerun: got t=%0d flt=%0d want t=109 flt=1", at - b, fault_cnt);
        end
    endtask

    task automatic test_restart;
        int b, at;
        req_restart = 1'b1;
        b = cyc;
        @(negedge clk);
        req_restart = 1'b0;
        n_checks++;
        if (pll_reset_n !== 1'b0 || rst_out !== 3'b111 || ready !== 1'b0 || fault_cnt !== 4'd1) begin
            n_fail++; $display("FAIL restart_outputs: got pll=%b rst=%b rdy=%b flt=%0d want 0 111 0 1",
                               pll_reset_n, rst_out, ready, fault_cnt);
        end
        // A restart during the PLL pulse must not stretch it.
        repeat (5) @(negedge clk);
        req_restart = 1'b1;
        @(negedge clk);
        req_restart = 1'b0;
        wait_until(0, 1'b1, 40, at);
        n_checks++;
        if (at !== b + 17) begin n_fail++; $display("FAIL restart_pulse: got %0d want %0d", at - b, 17); end
        wait_until(4, 1'b1, 200, at);
        n_checks++;
        if (at !== b + 107 || fault_cnt !== 4'd1) begin
            n_fail++; $display("FAIL restart_rerun: got t=%0d flt=%0d want t=107 flt=1", at - b, fault_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int b, at;
        pll_lock = 1'b0;
        b = cyc;
        repeat (2) @(negedge clk);
        req_restart = 1'b1;
        @(negedge clk);
        req_restart = 1'b0;
        n_checks++;
        if (fault_cnt !== 4'd2 || pll_reset_n !== 1'b0 || rst_out !== 3'b111) begin
            n_fail++; $display("FAIL coincide_fault: got flt=%0d pll=%b rst=%b want 2 0 111",
                               fault_cnt, pll_reset_n, rst_out);
        end
        pll_lock = 1'b1;
        wait_until(0, 1'b1, 40, at);
        n_checks++;
        if (at !== b + 19 || fault_cnt !== 4'd2) begin
            n_fail++; $display("FAIL coincide_single: got t=%0d flt=%0d want t=19 flt=2", at - b, fault_cnt);
        end
        wait_until(4, 1'b1, 200, at);
        n_checks++;
        if (at !== b + 109) begin n_fail++; $display("FAIL coincide_rerun: got %0d want %0d", at - b, 109); end
    endtask

    task automatic test_stability_glitch;
        int e, at;
        req_restart = 1'b1;
        @(negedge clk);
        req_restart = 1'b0;
        wait_until(0, 1'b1, 40, e);
        repeat (50) @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        wait_until(1, 1'b0, 300, at);
        n_checks++;
        if (e < 0 || at !== e + 125) begin
            n_fail++; $display("FAIL glitch_rel0: got %0d want %0d", at - e, 125);
        end
        wait_until(4, 1'b1, 40, at);
        n_checks++;
        if (at !== e + 141 || fault_cnt !== 4'd2) begin
            n_fail++; $display("FAIL glitch_ready: got t=%0d flt=%0d want t=141 flt=2", at - e, fault_cnt);
        end
    endtask

    task automatic test_timeout;
        int e, at;
        req_restart = 1'b1;
        pll_lock = 1'b0;
        @(negedge clk);
        req_restart = 1'b0;
        n_checks++;
        if (fault_cnt !== 4'd2) begin n_fail++; $display("FAIL tmo_restart_nofault: got %0d want 2", fault_cnt); end
        wait_until(0, 1'b1, 40, e);
        wait_until(0, 1'b0, 5000, at);
        n_checks++;
        if (e < 0 || at !== e + 4096 || fault_cnt !== 4'd3) begin
            n_fail++; $display("FAIL timeout1: got t=%0d flt=%0d want t=4096 flt=3", at - e, fault_cnt);
        end
        wait_until(0, 1'b1, 40, at);
        n_checks++;
        if (at !== e + 4112) begin n_fail++; $display("FAIL retry_pulse: got %0d want %0d", at - e, 4112); end
        wait_until(0, 1'b0, 5000, at);
        n_checks++;
        if (at !== e + 8208 || fault_cnt !== 4'd4) begin
            n_fail++; $display("FAIL timeout2: got t=%0d flt=%0d want t=8208 flt=4", at - e, fault_cnt);
        end
    endtask

    task automatic test_async_reset;
        int at;
        pll_lock = 1'b1;
        wait_until(1, 1'b0, 300, at);
        n_checks++;
        if (at < 0 || rst_out !== 3'b110 || ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_release: got rst=%b rdy=%b want 110 0", rst_out, ready);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (pll_reset_n !== 1'b0 || rst_out !== 3'b111 || ready !== 1'b0 || fault_cnt !== 4'd0) begin
            n_fail++; $display("FAIL async_reset: got pll=%b rst=%b rdy=%b flt=%0d want 0 111 0 0",
                               pll_reset_n, rst_out, ready, fault_cnt);
        end
    endtask

    task automatic test_saturate;
        int b;
        rst2_n = 1'b1;
        b = cyc;
        while (cyc < b + 539) @(negedge clk);
        n_checks++;
        if (fault_cnt2 !== 4'd14) begin n_fail++; $display("FAIL sat_before: got %0d want 14", fault_cnt2); end
        @(negedge clk);
        n_checks++;
        if (fault_cnt2 !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d want 15", fault_cnt2); end
        while (cyc < b + 721) @(negedge clk);
        n_checks++;
        if (fault_cnt2 !== 4'd15 || pll_reset_n2 !== 1'b0 || rst_out2 !== 2'b11) begin
            n_fail++; $display("FAIL sat_hold: got flt=%0d pll=%b rst=%b want 15 0 11",
                               fault_cnt2, pll_reset_n2, rst_out2);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_lock_loss();
        test_restart();
        test_back_to_back();
        test_stability_glitch();
        test_timeout();
        test_async_reset();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
